// File: rtl/writeback_queue_pkg.sv
// -----------------------------------------------------------------------------
// writeback_queue_pkg
// Shared definitions for the register-file write-back queue:
//   DATA_W / ADDR_W / NUM_REGS - register file geometry (16-bit, 32 registers)
//   wb_entry_t                 - one queued write {dest, data}
//   count_width()              - width of a 0..depth occupancy counter
// -----------------------------------------------------------------------------
package writeback_queue_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // An occupancy counter must represent 0..depth inclusive, hence depth+1.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/writeback_fifo.sv
// -----------------------------------------------------------------------------
// writeback_fifo
// In-order circular buffer of write-back entries.
//   clk, rst        - clock, asynchronous active-high reset
//   i_push          - write i_push_entry at the tail (ignored when full)
//   i_pop           - drop the head entry (ignored when empty)
//   o_full/o_empty  - occupancy flags
//   o_count         - number of occupied entries
//   o_head          - oldest entry
//   o_age_entry[i]  - entries in age order, index 0 = oldest
//   o_age_valid[i]  - o_age_entry[i] holds a live entry
// -----------------------------------------------------------------------------
module writeback_fifo
    import writeback_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  wb_entry_t        i_push_entry,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count,
    output wb_entry_t        o_head,
    output wb_entry_t        o_age_entry [DEPTH],
    output logic [DEPTH-1:0] o_age_valid
);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    wb_entry_t        r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; entries are only ever
    // observed through the count-qualified valid vector, so stale contents are
    // harmless and the array can map onto plain registers or RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_entry;
    end

    // Age-ordered view for the parent's youngest-first forwarding search.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_age_entry[i] = r_mem[r_rd_ptr + PTR_W'(i)];
            o_age_valid[i] = (CNT_W'(i) < r_count);
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// -----------------------------------------------------------------------------
// writeback_queue
// Write-side initiator for the 16-bit x 32 register file. Buffers results from
// the load unit (fixed priority) and the ALU, drains one entry per cycle onto
// a registered write port, and forwards pending data to two read addresses.
//   clk, rst                  - clock, asynchronous active-high reset
//   load_valid/dest/data      - load result handshake, load_ready back
//   alu_valid/dest/data       - ALU result handshake, alu_ready back
//   rf_hold                   - stall draining only
//   reg_write_en/dest/data    - registered register-file write port
//   fwd_addr_N -> fwd_hit_N / fwd_data_N (N = 1, 2)
//                             - youngest pending value for a read address
//   pending_count             - occupied queue entries
// -----------------------------------------------------------------------------
module writeback_queue #(
    parameter  int DATA_W = writeback_queue_pkg::DATA_W,
    parameter  int ADDR_W = writeback_queue_pkg::ADDR_W,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = writeback_queue_pkg::count_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_dest,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              rf_hold,
    output logic              reg_write_en,
    output logic [ADDR_W-1:0] reg_write_dest,
    output logic [DATA_W-1:0] reg_write_data,
    input  logic [ADDR_W-1:0] fwd_addr_1,
    output logic              fwd_hit_1,
    output logic [DATA_W-1:0] fwd_data_1,
    input  logic [ADDR_W-1:0] fwd_addr_2,
    output logic              fwd_hit_2,
    output logic [DATA_W-1:0] fwd_data_2,
    output logic [CNT_W-1:0]  pending_count
);

    import writeback_queue_pkg::wb_entry_t;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_can_accept;
    logic             w_push;
    logic             w_pop;
    wb_entry_t        w_push_entry;
    wb_entry_t        w_head;
    wb_entry_t        w_age_entry [DEPTH];
    logic [DEPTH-1:0] w_age_valid;

    logic             r_wr_en;
    wb_entry_t        r_wr_entry;

    // Ready depends only on occupancy; a pop this cycle frees space next cycle.
    assign w_can_accept = !w_fifo_full;
    assign load_ready   = w_can_accept;
    assign alu_ready    = w_can_accept && !load_valid;

    // At most one enqueue per cycle, load unit first.
    assign w_push       = w_can_accept && (load_valid || alu_valid);
    assign w_push_entry = load_valid ? '{dest: load_dest, data: load_data}
                                     : '{dest: alu_dest,  data: alu_data};

    // Popping is gated on the pre-edge count, so an entry pushed into an empty
    // queue cannot leave on the same edge.
    assign w_pop = !w_fifo_empty && !rf_hold;

    writeback_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_full       (w_fifo_full),
        .o_empty      (w_fifo_empty),
        .o_count      (pending_count),
        .o_head       (w_head),
        .o_age_entry  (w_age_entry),
        .o_age_valid  (w_age_valid)
    );

    // Registered write port: dest/data hold their last value when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en    <= 1'b0;
            r_wr_entry <= '0;
        end else if (w_pop) begin
            r_wr_en    <= 1'b1;
            r_wr_entry <= w_head;
        end else begin
            r_wr_en    <= 1'b0;
        end
    end

    assign reg_write_en   = r_wr_en;
    assign reg_write_dest = r_wr_entry.dest;
    assign reg_write_data = r_wr_entry.data;

    // Forwarding: the write port is the oldest pending value, then queue
    // entries oldest to youngest, so the last match found is the youngest.
    // NOTE: every output gets a default before any condition so the block is
    // purely combinational and no latch is inferred.
    always_comb begin
        fwd_hit_1  = 1'b0;
        fwd_data_1 = '0;
        fwd_hit_2  = 1'b0;
        fwd_data_2 = '0;

        if (r_wr_en && (r_wr_entry.dest == fwd_addr_1)) begin
            fwd_hit_1  = 1'b1;
            fwd_data_1 = r_wr_entry.data;
        end
        if (r_wr_en && (r_wr_entry.dest == fwd_addr_2)) begin
            fwd_hit_2  = 1'b1;
            fwd_data_2 = r_wr_entry.data;
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (w_age_valid[i] && (w_age_entry[i].dest == fwd_addr_1)) begin
                fwd_hit_1  = 1'b1;
                fwd_data_1 = w_age_entry[i].data;
            end
            if (w_age_valid[i] && (w_age_entry[i].dest == fwd_addr_2)) begin
                fwd_hit_2  = 1'b1;
                fwd_data_2 = w_age_entry[i].data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// -----------------------------------------------------------------------------
// tb_writeback_queue
// Self-checking bench for writeback_queue. Accepted results are pushed to a
// scoreboard at the handshake; every write seen on the register-file port is
// popped and compared. Directed checks cover latency, priority, full/hold,
// forwarding priority and reset mid-drain.
// -----------------------------------------------------------------------------
module tb_writeback_queue;

    import writeback_queue_pkg::*;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic [4:0]  load_dest;
    logic [15:0] load_data;
    logic        load_ready;
    logic        alu_valid;
    logic [4:0]  alu_dest;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        rf_hold;
    logic        reg_write_en;
    logic [4:0]  reg_write_dest;
    logic [15:0] reg_write_data;
    logic [4:0]  fwd_addr_1;
    logic        fwd_hit_1;
    logic [15:0] fwd_data_1;
    logic [4:0]  fwd_addr_2;
    logic        fwd_hit_2;
    logic [15:0] fwd_data_2;
    logic [2:0]  pending_count;

    int n_checks = 0;
    int n_fail   = 0;

    wb_entry_t sb [$];

    writeback_queue dut (
        .clk            (clk),
        .rst            (rst),
        .load_valid     (load_valid),
        .load_dest      (load_dest),
        .load_data      (load_data),
        .load_ready     (load_ready),
        .alu_valid      (alu_valid),
        .alu_dest       (alu_dest),
        .alu_data       (alu_data),
        .alu_ready      (alu_ready),
        .rf_hold        (rf_hold),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .fwd_addr_1     (fwd_addr_1),
        .fwd_hit_1      (fwd_hit_1),
        .fwd_data_1     (fwd_data_1),
        .fwd_addr_2     (fwd_addr_2),
        .fwd_hit_2      (fwd_hit_2),
        .fwd_data_2     (fwd_data_2),
        .pending_count  (pending_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Move to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one result and hold it until accepted; returns just after the
    // accepting edge with valid dropped.
    task automatic drive(input bit is_load, input logic [4:0] dest, input logic [15:0] data);
        bit accepted;
        accepted = 1'b0;
        if (is_load) begin
            load_valid = 1'b1; load_dest = dest; load_data = data;
        end else begin
            alu_valid = 1'b1; alu_dest = dest; alu_data = data;
        end
        for (int c = 0; c < 20 && !accepted; c++) begin
            @(negedge clk);
            accepted = is_load ? load_ready : alu_ready;
        end
        check("accept_in_time", accepted, 1);
        tick();
        load_valid = 1'b0;
        alu_valid  = 1'b0;
    endtask

    // Scoreboard: record accepted results, compare every issued write.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (reg_write_en) begin
                check("wr_expected", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    wb_entry_t e;
                    e = sb.pop_front();
                    check("wr_dest", reg_write_dest, e.dest);
                    check("wr_data", reg_write_data, e.data);
                end
            end
            if (load_valid && load_ready)
                sb.push_back('{dest: load_dest, data: load_data});
            else if (alu_valid && alu_ready)
                sb.push_back('{dest: alu_dest, data: alu_data});
        end
    end

    initial begin
        int n_wr;
        rst = 1'b1;
        load_valid = 0; load_dest = 0; load_data = 0;
        alu_valid  = 0; alu_dest  = 0; alu_data  = 0;
        rf_hold = 0; fwd_addr_1 = 0; fwd_addr_2 = 0;

        // Reset state
        #2;
        check("rst_count", pending_count, 0);
        check("rst_en", reg_write_en, 0);
        check("rst_dest", reg_write_dest, 0);
        check("rst_data", reg_write_data, 0);
        check("rst_hit1", fwd_hit_1, 0);
        check("rst_hit2", fwd_hit_2, 0);
        #10 rst = 1'b0;
        @(negedge clk);
        check("rst_load_ready", load_ready, 1);
        check("rst_alu_ready", alu_ready, 1);

        // Single load: write port two edges after valid
        tick();
        load_valid = 1; load_dest = 5'd3; load_data = 16'h00AA;
        @(negedge clk);
        check("t1_load_ready", load_ready, 1);
        tick();
        load_valid = 0;
        @(negedge clk);
        check("t1_count_1", pending_count, 1);
        check("t1_en_early", reg_write_en, 0);
        tick();
        @(negedge clk);
        check("t1_en", reg_write_en, 1);
        check("t1_dest", reg_write_dest, 3);
        check("t1_data", reg_write_data, 16'h00AA);
        check("t1_count_0", pending_count, 0);
        tick();
        @(negedge clk);
        check("t1_en_off", reg_write_en, 0);
        check("t1_dest_hold", reg_write_dest, 3);

        // Load and ALU together: load wins, writes in order
        load_valid = 1; load_dest = 5'd2; load_data = 16'h1111;
        alu_valid  = 1; alu_dest  = 5'd7; alu_data  = 16'h2222;
        @(negedge clk);
        check("t2_alu_ready_blocked", alu_ready, 0);
        check("t2_load_ready", load_ready, 1);
        tick();
        load_valid = 0;
        @(negedge clk);
        check("t2_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 0;
        @(negedge clk);
        check("t2_first_dest", reg_write_dest, 2);
        check("t2_first_en", reg_write_en, 1);
        tick();
        @(negedge clk);
        check("t2_second_dest", reg_write_dest, 7);
        check("t2_second_en", reg_write_en, 1);
        tick();

        // Fill under rf_hold, fifth result held, then drain one per cycle
        rf_hold = 1;
        for (int i = 0; i < 4; i++) drive(1'b0, 5'(10 + i), 16'h3000 + 16'(i));
        alu_valid = 1; alu_dest = 5'd14; alu_data = 16'h3004;
        @(negedge clk);
        check("t3_full_count", pending_count, 4);
        check("t3_full_alu_ready", alu_ready, 0);
        check("t3_full_load_ready", load_ready, 0);
        check("t3_hold_en", reg_write_en, 0);
        tick();
        tick();
        @(negedge clk);
        check("t3_still_full", pending_count, 4);
        check("t3_still_blocked", alu_ready, 0);
        tick();
        rf_hold = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 1) alu_valid = 0;
            @(negedge clk);
            check("t3_drain_en", reg_write_en, 1);
            check("t3_drain_count", pending_count, (k == 0) ? 3 : 4 - k);
        end
        tick();
        @(negedge clk);
        check("t3_idle_en", reg_write_en, 0);

        // Forwarding: youngest queued wins; new push not visible before edge
        tick();
        rf_hold = 1; fwd_addr_1 = 5'd5; fwd_addr_2 = 5'd6;
        drive(1'b1, 5'd5, 16'h0001);
        load_valid = 1; load_dest = 5'd5; load_data = 16'h0002;
        @(negedge clk);
        check("t4_pre_hit1", fwd_hit_1, 1);
        check("t4_pre_data1", fwd_data_1, 16'h0001);
        tick();
        load_valid = 0;
        @(negedge clk);
        check("t4_hit1", fwd_hit_1, 1);
        check("t4_data1", fwd_data_1, 16'h0002);
        check("t4_hit2", fwd_hit_2, 0);
        check("t4_data2", fwd_data_2, 0);
        tick();
        rf_hold = 0;
        tick();
        @(negedge clk);
        check("t4_port_old", reg_write_data, 16'h0001);
        check("t4_queue_over_port", fwd_data_1, 16'h0002);
        tick();
        @(negedge clk);
        check("t4_port_new_hit", fwd_hit_1, 1);
        check("t4_port_new_data", fwd_data_1, 16'h0002);
        check("t4_count0", pending_count, 0);
        tick();
        @(negedge clk);
        check("t4_gone_hit", fwd_hit_1, 0);
        check("t4_gone_data", fwd_data_1, 0);

        // Forwarding from the write port only
        tick();
        fwd_addr_1 = 5'd9; fwd_addr_2 = 5'd9;
        drive(1'b1, 5'd9, 16'hBEEF);
        @(negedge clk);
        check("t5_queue_hit", fwd_hit_1, 1);
        check("t5_queue_data", fwd_data_1, 16'hBEEF);
        tick();
        @(negedge clk);
        check("t5_port_en", reg_write_en, 1);
        check("t5_port_hit1", fwd_hit_1, 1);
        check("t5_port_data1", fwd_data_1, 16'hBEEF);
        check("t5_port_hit2", fwd_hit_2, 1);
        check("t5_port_data2", fwd_data_2, 16'hBEEF);
        tick();
        @(negedge clk);
        check("t5_after_hit", fwd_hit_1, 0);
        check("t5_after_data", fwd_data_1, 0);

        // Register 0 issues like any other
        tick();
        drive(1'b0, 5'd0, 16'h0F0F);
        tick();
        @(negedge clk);
        check("t6_r0_en", reg_write_en, 1);
        check("t6_r0_dest", reg_write_dest, 0);
        check("t6_r0_data", reg_write_data, 16'h0F0F);
        tick();

        // Reset mid-drain: 3 queued plus one on the port
        rf_hold = 1; fwd_addr_1 = 5'd21;
        for (int i = 0; i < 4; i++) drive(1'b0, 5'(20 + i), 16'h4000 + 16'(i));
        rf_hold = 0;
        tick();
        check("t7_pre_en", reg_write_en, 1);
        check("t7_pre_count", pending_count, 3);
        #2 rst = 1'b1;
        #1;
        check("t7_rst_en", reg_write_en, 0);
        check("t7_rst_count", pending_count, 0);
        check("t7_rst_dest", reg_write_dest, 0);
        check("t7_rst_data", reg_write_data, 0);
        check("t7_rst_hit1", fwd_hit_1, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        n_wr = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (reg_write_en) n_wr++;
        end
        check("t7_no_writes", n_wr, 0);
        check("t7_ready", load_ready, 1);
        check("t7_alu_ready", alu_ready, 1);

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
